// File: rtl/fht_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : fht_pkg                                                |
// | Description : Shared types and helpers for the radix-2 FHT core:     |
// |               sequencer state enum, clog2, stage-counter width and   |
// |               the bit-reverse used by the address generator and the  |
// |               data-memory controller.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package fht_pkg;

   // Sequencer states of the twiddle address generator
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_GAP   = 2'd2,
      ST_FLUSH = 2'd3
   } fht_state_t;

   // Ceiling log2; returns 0 for values of 0 or 1
   function automatic int fht_clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Width of the stage counter / oSTAGE port for a 2^n_bit point transform
   function automatic int fht_stage_w(input int n_bit);
      return fht_clog2(n_bit) + 1;
   endfunction

   // Reverse the low nbits of value; bits above nbits come back as zero
   function automatic logic [31:0] fht_bitrev(input logic [31:0] value, input int nbits);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < nbits) begin
            r[i] = value[nbits-1-i];
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fht_align_pipe.sv
// +----------------------------------------------------------------------+
// | Module      : fht_align_pipe                                         |
// | Description : DEPTH-deep register pipe with asynchronous clear, used |
// |               to match sideband timing to the ROM read latency.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module fht_align_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            // First stage captures the new word every cycle
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  r_pipe[0] <= '0;
               end else begin
                  r_pipe[0] <= i_d;
               end
            end
         end else begin : g_body
            // Later stages shift unconditionally so latency is fixed
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  r_pipe[gi] <= '0;
               end else begin
                  r_pipe[gi] <= r_pipe[gi-1];
               end
            end
         end
      end
   endgenerate

   assign o_q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/fht_tw_addr_gen.sv
// +----------------------------------------------------------------------+
// | Module      : fht_tw_addr_gen                                        |
// | Description : Stage/butterfly sequencer for an in-place radix-2 FHT. |
// |               Drives the twiddle ROM address and emits quadrant      |
// |               select, data indices and stage sideband aligned to the |
// |               ROM read latency.                                      |
// |               Optional: define FHT_BITREV_EN to bit-reverse oIDX_A / |
// |               oIDX_B over N_BIT bits.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module fht_tw_addr_gen
   import fht_pkg::*;
#(
   parameter int N_BIT   = 10,
   parameter int A_BIT   = 10,
   parameter int ROM_LAT = 1,
   parameter int GAP     = 4
) (
   input  logic                            iCLK,
   input  logic                            iRESET,
   input  logic                            iSTART,
   input  logic                            iREADY,
   output logic [A_BIT-1:0]                oADDR,
   output logic                            oBUSY,
   output logic                            oSEL,
   output logic [N_BIT-1:0]                oIDX_A,
   output logic [N_BIT-1:0]                oIDX_B,
   output logic [fht_stage_w(N_BIT)-1:0]   oSTAGE,
   output logic                            oVALID,
   output logic                            oSTAGE_END,
   output logic                            oDONE
);

   localparam int c_sw = fht_stage_w(N_BIT);
   localparam int c_jw = (N_BIT > 1) ? N_BIT - 1 : 1;
   localparam int c_gw = (GAP > 1) ? fht_clog2(GAP) : 1;
   localparam int c_fw = (ROM_LAT > 1) ? fht_clog2(ROM_LAT) : 1;
   localparam int c_pw = 3 + 2 * N_BIT + c_sw;

   localparam logic [c_sw-1:0] c_s_one  = c_sw'(1);
   localparam logic [c_sw-1:0] c_s_last = c_sw'(N_BIT - 1);
   localparam logic [c_jw-1:0] c_j_one  = c_jw'(1);
   localparam logic [c_jw-1:0] c_j_last = c_jw'((1 << (N_BIT - 1)) - 1);
   localparam logic [c_gw-1:0] c_g_one  = c_gw'(1);
   localparam logic [c_gw-1:0] c_g_last = c_gw'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [c_fw-1:0] c_f_one  = c_fw'(1);
   localparam logic [c_fw-1:0] c_f_last = c_fw'(ROM_LAT - 1);

   // Position of butterfly j inside its group: k = j mod 2^s
   function automatic logic [N_BIT-1:0] f_k(input logic [c_sw-1:0] s, input logic [c_jw-1:0] j);
      logic [N_BIT-1:0] mask;
      mask = (N_BIT'(1) << s) - N_BIT'(1);
      return N_BIT'(j) & mask;
   endfunction

   // Quarter-period in k units (M/4); zero for the first stage
   function automatic logic [N_BIT-1:0] f_q(input logic [c_sw-1:0] s);
      return (s == '0) ? '0 : (N_BIT'(1) << (s - c_s_one));
   endfunction

   // Upper-wing index: group base (g * 2^(s+1)) plus offset k
   function automatic logic [N_BIT-1:0] f_idx_a(input logic [c_sw-1:0] s, input logic [c_jw-1:0] j);
      logic [N_BIT-1:0] g;
      g = N_BIT'(j) >> s;
      return (g << (s + c_s_one)) | f_k(s, j);
   endfunction

   // Second quadrant when the angle 2*pi*k/M reaches pi/2
   function automatic logic f_sel(input logic [c_sw-1:0] s, input logic [c_jw-1:0] j);
      return (f_q(s) != '0) && (f_k(s, j) >= f_q(s));
   endfunction

   // Angle folded into [0, pi/2) and scaled to the ROM address range
   function automatic logic [A_BIT-1:0] f_addr(input logic [c_sw-1:0] s, input logic [c_jw-1:0] j);
      logic [N_BIT-1:0] kq;
      int               sh;
      kq = f_sel(s, j) ? (f_k(s, j) - f_q(s)) : f_k(s, j);
      sh = A_BIT + 1 - int'(s);
      return A_BIT'((A_BIT + 2)'(kq) << sh);
   endfunction

   fht_state_t         r_state;
   fht_state_t         w_state_nxt;
   logic [c_sw-1:0]    r_s;
   logic [c_sw-1:0]    w_s_nxt;
   logic [c_jw-1:0]    r_j;
   logic [c_jw-1:0]    w_j_nxt;
   logic [c_gw-1:0]    r_gcnt;
   logic [c_gw-1:0]    w_gcnt_nxt;
   logic [c_fw-1:0]    r_fcnt;
   logic [c_fw-1:0]    w_fcnt_nxt;
   logic [A_BIT-1:0]   r_addr;
   logic [A_BIT-1:0]   w_addr_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic               w_fire;
   logic               w_last;
   logic               w_sel;
   logic [N_BIT-1:0]   w_idx_a;
   logic [N_BIT-1:0]   w_idx_b;
   logic [N_BIT-1:0]   w_ia_out;
   logic [N_BIT-1:0]   w_ib_out;
   logic [c_pw-1:0]    w_pipe_d;
   logic [c_pw-1:0]    w_pipe_q;

   assign w_last  = (r_j == c_j_last);
   assign w_sel   = f_sel(r_s, r_j);
   assign w_idx_a = f_idx_a(r_s, r_j);
   assign w_idx_b = w_idx_a | (N_BIT'(1) << r_s);

`ifdef FHT_BITREV_EN
   assign w_ia_out = N_BIT'(fht_bitrev(32'(w_idx_a), N_BIT));
   assign w_ib_out = N_BIT'(fht_bitrev(32'(w_idx_b), N_BIT));
`else
   assign w_ia_out = w_idx_a;
   assign w_ib_out = w_idx_b;
`endif

   // State, counters and the ROM address register
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_j     <= '0;
         r_gcnt  <= '0;
         r_fcnt  <= '0;
         r_addr  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_s     <= w_s_nxt;
         r_j     <= w_j_nxt;
         r_gcnt  <= w_gcnt_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_done  <= w_done_nxt;
         if (w_fire) begin
            r_addr <= w_addr_nxt;
         end
      end
   end

   // Next-state logic: walk butterflies, insert stage gaps, flush the pipe
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_j_nxt     = r_j;
      w_gcnt_nxt  = r_gcnt;
      w_fcnt_nxt  = r_fcnt;
      w_done_nxt  = 1'b0;
      w_fire      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (iSTART) begin
               w_state_nxt = ST_RUN;
               w_s_nxt     = '0;
               w_j_nxt     = '0;
            end
         end
         ST_RUN: begin
            if (iREADY) begin
               w_fire = 1'b1;
               if (w_last) begin
                  w_j_nxt = '0;
                  if (r_s == c_s_last) begin
                     w_state_nxt = ST_FLUSH;
                     w_s_nxt     = '0;
                     w_fcnt_nxt  = '0;
                  end else begin
                     w_s_nxt     = r_s + c_s_one;
                     w_gcnt_nxt  = '0;
                     w_state_nxt = (GAP == 0) ? ST_RUN : ST_GAP;
                  end
               end else begin
                  w_j_nxt = r_j + c_j_one;
               end
            end
         end
         ST_GAP: begin
            if (r_gcnt == c_g_last) begin
               w_gcnt_nxt  = '0;
               w_state_nxt = ST_RUN;
            end else begin
               w_gcnt_nxt = r_gcnt + c_g_one;
            end
         end
         ST_FLUSH: begin
            if (r_fcnt == c_f_last) begin
               w_fcnt_nxt  = '0;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_fcnt_nxt = r_fcnt + c_f_one;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Address for the butterfly that becomes current after this fire
   always_comb begin
      w_addr_nxt = f_addr(w_s_nxt, w_j_nxt);
   end

   assign w_pipe_d = {w_fire, w_sel, w_ia_out, w_ib_out, r_s, w_fire & w_last};

   fht_align_pipe #(
      .WIDTH (c_pw),
      .DEPTH (ROM_LAT)
   ) u_align (
      .clk (iCLK),
      .rst (iRESET),
      .i_d (w_pipe_d),
      .o_q (w_pipe_q)
   );

   assign {oVALID, oSEL, oIDX_A, oIDX_B, oSTAGE, oSTAGE_END} = w_pipe_q;
   assign oADDR = r_addr;
   assign oBUSY = (r_state == ST_RUN) || (r_state == ST_GAP);
   assign oDONE = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fht_tw_addr_gen.sv
// +----------------------------------------------------------------------+
// | Module      : tb_fht_tw_addr_gen                                     |
// | Description : Self-checking bench for fht_tw_addr_gen (N_BIT=3,      |
// |               A_BIT=10, ROM_LAT=1, GAP=2) against a butterfly-list   |
// |               model and a latency-matched ROM model. Honours         |
// |               FHT_BITREV_EN when defined.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_fht_tw_addr_gen;
   import fht_pkg::*;

   localparam int N_BIT   = 3;
   localparam int A_BIT   = 10;
   localparam int ROM_LAT = 1;
   localparam int GAP     = 2;
   localparam int N       = 1 << N_BIT;
   localparam int SW      = fht_stage_w(N_BIT);
   localparam int NBFLY   = N_BIT * N / 2;

   typedef struct {
      int a;
      int b;
      int sel;
      int addr;
      int stage;
      int last;
   } bfly_t;

   logic             iCLK   = 1'b0;
   logic             iRESET = 1'b1;
   logic             iSTART = 1'b0;
   logic             iREADY = 1'b0;
   logic [A_BIT-1:0] oADDR;
   logic             oBUSY;
   logic             oSEL;
   logic [N_BIT-1:0] oIDX_A;
   logic [N_BIT-1:0] oIDX_B;
   logic [SW-1:0]    oSTAGE;
   logic             oVALID;
   logic             oSTAGE_END;
   logic             oDONE;

   bfly_t            exp_q[$];
   bfly_t            cur;
   int               checks     = 0;
   int               failures   = 0;
   int               valid_cnt  = 0;
   int               done_cnt   = 0;
   logic             prev_valid = 1'b0;
   logic [3:0]       ready_pat  = 4'b1001;
   logic [A_BIT-1:0] rom_pipe [ROM_LAT];

   fht_tw_addr_gen #(
      .N_BIT   (N_BIT),
      .A_BIT   (A_BIT),
      .ROM_LAT (ROM_LAT),
      .GAP     (GAP)
   ) dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iSTART     (iSTART),
      .iREADY     (iREADY),
      .oADDR      (oADDR),
      .oBUSY      (oBUSY),
      .oSEL       (oSEL),
      .oIDX_A     (oIDX_A),
      .oIDX_B     (oIDX_B),
      .oSTAGE     (oSTAGE),
      .oVALID     (oVALID),
      .oSTAGE_END (oSTAGE_END),
      .oDONE      (oDONE)
   );

   always #5 iCLK = ~iCLK;

   // Reference ROM: arbitrary content, read latency ROM_LAT
   function automatic logic [A_BIT-1:0] rom_f(input logic [A_BIT-1:0] a);
      return A_BIT'(a * 5 + 17);
   endfunction

   always @(posedge iCLK) begin
      rom_pipe[0] <= rom_f(oADDR);
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end

   function automatic int brev(input int v);
`ifdef FHT_BITREV_EN
      int r = 0;
      for (int i = 0; i < N_BIT; i++) if (v & (1 << i)) r |= 1 << (N_BIT - 1 - i);
      return r;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Butterfly list of a full run: groups of size M, pairs (base+k, base+k+M/2)
   task automatic build_run();
      exp_q.delete();
      for (int s = 0; s < N_BIT; s++) begin
         int m    = 1 << (s + 1);
         int half = m / 2;
         for (int base = 0; base < N; base += m) begin
            for (int k = 0; k < half; k++) begin
               bfly_t  e;
               longint num;
               e.a     = brev(base + k);
               e.b     = brev(base + k + half);
               e.sel   = (4 * k >= m) ? 1 : 0;
               num     = longint'(4 * k - e.sel * m) * (longint'(1) << A_BIT) / m;
               e.addr  = int'(num % (longint'(1) << A_BIT));
               e.stage = s;
               e.last  = (base + k + half == N - 1) ? 1 : 0;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   // Compare every meaningful output cycle against the model
   always @(negedge iCLK) begin
      if (!iRESET) begin
         if (oVALID) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_valid actual=1 required=0 (idx_a=%0d idx_b=%0d)", oIDX_A, oIDX_B);
            end else begin
               cur = exp_q.pop_front();
               chk("idx_a", oIDX_A, cur.a);
               chk("idx_b", oIDX_B, cur.b);
               chk("sel", oSEL, cur.sel);
               chk("stage", oSTAGE, cur.stage);
               chk("stage_end", oSTAGE_END, cur.last);
               chk("rom_q", rom_pipe[ROM_LAT-1], rom_f(A_BIT'(cur.addr)));
            end
         end else begin
            chk("stage_end_without_valid", oSTAGE_END, 0);
         end
         if (oDONE) begin
            done_cnt++;
            chk("done_after_last_valid", {prev_valid, exp_q.size() == 0, oVALID}, 3'b110);
         end
         prev_valid = oVALID;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_addr"}, oADDR, 0);
      chk({tag, "_busy"}, oBUSY, 0);
      chk({tag, "_valid"}, oVALID, 0);
      chk({tag, "_sel"}, oSEL, 0);
      chk({tag, "_idx"}, {oIDX_A, oIDX_B}, 0);
      chk({tag, "_stage"}, oSTAGE, 0);
      chk({tag, "_flags"}, {oSTAGE_END, oDONE}, 0);
   endtask

   // Start a run, then reset while stage 1 butterfly 1 is current
   task automatic run_abort();
      valid_cnt = 0;
      build_run();
      iSTART = 1'b1;
      iREADY = 1'b1;
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      repeat (7) @(posedge iCLK);
      #1 iRESET = 1'b1;
      @(negedge iCLK);
      check_zero("abort");
      chk("abort_valid_count", valid_cnt, N / 2);
      exp_q.delete();
      prev_valid = 1'b0;
      @(posedge iCLK); #1;
      iRESET = 1'b0;
      iREADY = 1'b0;
      @(negedge iCLK);
      chk("idle_after_abort_busy", oBUSY, 0);
      @(posedge iCLK); #1;
   endtask

   // One complete run; mode 0 = ready high, 1 = ready 1,0,0,1, 2 = random
   task automatic do_run(input int mode);
      int   cyc = 0;
      bit   done = 0;
      bit   last_busy = 0;
      bit   tracking = 0;
      int   busy_cycles = 0;
      int   gap_len = 0;
      int   gap_idle = 0;
      int   gaps[$];
      int   gap_idles[$];
      valid_cnt = 0;
      done_cnt  = 0;
      build_run();
      iREADY = 1'b0;
      iSTART = 1'b1;
      @(posedge iCLK); #1;
      while (!done && cyc < 400) begin
         case (mode)
            0:       iREADY = 1'b1;
            1:       iREADY = ready_pat[3 - (cyc % 4)];
            default: iREADY = ($urandom_range(0, 2) != 0);
         endcase
         iSTART = last_busy && ((mode == 0) ? (cyc == 2 || cyc == 5) : ($urandom_range(0, 5) == 0));
         @(negedge iCLK);
         last_busy = oBUSY;
         if (oBUSY) busy_cycles++;
         if (oVALID && oSTAGE_END) begin
            tracking = 1;
            gap_len  = 0;
            gap_idle = 0;
         end else if (tracking && !oVALID) begin
            gap_len++;
            if (!oBUSY) gap_idle++;
         end else if (tracking && oVALID) begin
            gaps.push_back(gap_len);
            gap_idles.push_back(gap_idle);
            tracking = 0;
         end
         if (oDONE) done = 1;
         @(posedge iCLK); #1;
         cyc++;
      end
      iSTART = 1'b0;
      iREADY = 1'b0;
      chk("run_done_seen", done, 1);
      chk("valid_count", valid_cnt, NBFLY);
      chk("done_count", done_cnt, 1);
      chk("queue_drained", exp_q.size(), 0);
      if (mode == 0) begin
         chk("busy_cycles", busy_cycles, NBFLY + (N_BIT - 1) * GAP);
         chk("gap_count", gaps.size(), N_BIT - 1);
         foreach (gaps[i]) begin
            chk("gap_length", gaps[i], GAP);
            chk("gap_busy_low_cycles", gap_idles[i], 0);
         end
      end
      repeat (3) @(posedge iCLK);
      #1;
      chk("idle_after_run_busy", oBUSY, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      iRESET = 1'b1;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      check_zero("reset");
      @(posedge iCLK); #1;
      iRESET = 1'b0;

      // Pin the model with hand-derived entries
      build_run();
      chk("model_s1j1_sel", exp_q[5].sel, 1);
      chk("model_s1j1_addr", exp_q[5].addr, 0);
      chk("model_s2j1_addr", exp_q[9].addr, 512);
      chk("model_s2j2_sel_addr", {exp_q[10].sel, exp_q[10].addr}, {32'd1, 32'd0});
      chk("model_s2j3_last", {exp_q[11].sel, exp_q[11].addr, exp_q[11].last}, {32'd1, 32'd512, 32'd1});
`ifdef FHT_BITREV_EN
      chk("model_s0_idx", {exp_q[0].b, exp_q[1].a, exp_q[1].b, exp_q[2].a, exp_q[3].b},
          {32'd4, 32'd2, 32'd6, 32'd1, 32'd7});
`else
      chk("model_s0_idx", {exp_q[0].b, exp_q[1].a, exp_q[1].b, exp_q[2].a, exp_q[3].b},
          {32'd1, 32'd2, 32'd3, 32'd4, 32'd7});
      chk("model_s2_idx", {exp_q[9].a, exp_q[9].b, exp_q[11].a, exp_q[11].b},
          {32'd1, 32'd5, 32'd3, 32'd7});
`endif

      run_abort();
      do_run(0);
      do_run(1);
      do_run(2);
      do_run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
